serial_link_lane_align: RTL and testbench

- Multi-lane receive-side word aligner and deskewer for the serial link PHY; sits between the per-lane deserialisers and the link-layer unpacker.
- Generalises the fixed 4-wire DDR link to NumLanes lanes. Adds per-lane bit-slip word alignment, cross-lane marker-based deskew, and a training-status FSM with timeout and error reporting.
- Link layer may accept traffic only once train_done_o is high.

---
 rtl/serial_link_lane_align.sv | 245 ++++++++++++++++++++++++
 tb/tb_serial_link_lane_align.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_link_lane_align.sv
// Receive-side word aligner and deskewer for the multi-lane serial link.
// Each lane bit-slips until it sees the training word LockCount times in a row.
// A one-shot marker word then measures inter-lane skew, and per-lane delay lines
// re-align the lanes before the words are handed to the link layer.

module serial_link_lane_align_lane #(
    parameter int                   WordWidth    = 8,
    parameter logic [WordWidth-1:0] TrainPattern = 8'hA5,
    parameter int                   LockCount    = 8,
    parameter int                   MaxSkew      = 4,
    localparam int                  OffW         = $clog2(WordWidth),
    localparam int                  CntW         = $clog2(LockCount + 1),
    localparam int                  DlyW         = $clog2(MaxSkew + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 slip_en_i,
    input  logic                 adv_i,
    input  logic [WordWidth-1:0] word_i,
    input  logic [DlyW-1:0]      dly_i,
    output logic [WordWidth-1:0] rot_o,
    output logic [WordWidth-1:0] tap_o,
    output logic [OffW-1:0]      offset_o,
    output logic                 locked_o
);
    logic [OffW-1:0]                 offset_q, offset_d;
    logic [CntW-1:0]                 cnt_q, cnt_d;
    logic                            locked_q, locked_d;
    logic [MaxSkew:1][WordWidth-1:0] sr_q, sr_d;
    logic [2*WordWidth-1:0]          dbl;

    // Rotate left by the current offset: top half of the doubled word shifted.
    assign dbl      = {word_i, word_i} << offset_q;
    assign rot_o    = dbl[2*WordWidth-1 -: WordWidth];
    assign offset_o = offset_q;
    assign locked_o = locked_q;

    // Bit-slip search: count consecutive training words, slip one bit on a miss.
    always_comb begin
        offset_d = offset_q;
        cnt_d    = cnt_q;
        locked_d = locked_q;
        if (clr_i) begin
            offset_d = '0;
            cnt_d    = '0;
            locked_d = 1'b0;
        end else if (slip_en_i && !locked_q) begin
            if (rot_o == TrainPattern) begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(LockCount - 1)) locked_d = 1'b1;
            end else begin
                cnt_d    = '0;
                offset_d = (offset_q == OffW'(WordWidth - 1)) ? '0 : offset_q + OffW'(1);
            end
        end
    end

    // Delay line of past aligned words; tap 0 is the current word itself.
    always_comb begin
        sr_d = sr_q;
        if (adv_i) begin
            sr_d[1] = rot_o;
            for (int k = 2; k <= MaxSkew; k++) sr_d[k] = sr_q[k-1];
        end
    end

    // Output tap selection by programmed lane delay.
    always_comb begin
        tap_o = rot_o;
        for (int k = 1; k <= MaxSkew; k++)
            if (dly_i == DlyW'(k)) tap_o = sr_q[k];
    end

    // Lane state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            offset_q <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            sr_q     <= '0;
        end else begin
            offset_q <= offset_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            sr_q     <= sr_d;
        end
    end
endmodule

module serial_link_lane_align #(
    parameter int                   NumLanes      = 4,
    parameter int                   WordWidth     = 8,
    parameter logic [WordWidth-1:0] TrainPattern  = 8'hA5,
    parameter logic [WordWidth-1:0] MarkerWord    = 8'h3C,
    parameter int                   LockCount     = 8,
    parameter int                   MaxSkew       = 4,
    parameter int                   TimeoutCycles = 1024
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  train_start_i,
    input  logic [NumLanes*WordWidth-1:0]         lane_data_i,
    input  logic                                  lane_valid_i,
    output logic [NumLanes*WordWidth-1:0]         data_o,
    output logic                                  valid_o,
    output logic [NumLanes-1:0]                   lane_locked_o,
    output logic [NumLanes*$clog2(WordWidth)-1:0] bitslip_o,
    output logic                                  train_done_o,
    output logic                                  train_err_o
);
    localparam int OffW = $clog2(WordWidth);
    localparam int DlyW = $clog2(MaxSkew + 1);
    localparam int TmW  = $clog2(TimeoutCycles);
    localparam int WcW  = TmW + 1;

    typedef enum logic [2:0] {S_IDLE, S_BITALIGN, S_DESKEW, S_DONE, S_ERROR} state_e;

    state_e                             state_q;
    logic [NumLanes-1:0][WordWidth-1:0] rot, tap, data_q;
    logic [NumLanes-1:0][OffW-1:0]      offset;
    logic [NumLanes-1:0]                locked, seen_q;
    logic [NumLanes-1:0][DlyW-1:0]      dly_q;
    logic [NumLanes-1:0][WcW-1:0]       arr_q, skew;
    logic [WcW-1:0]                     wcnt_q, arr_max;
    logic [TmW-1:0]                     tmr_q;
    logic                               slip_en, timeout, skew_bad;
    logic                               valid_q, done_q, err_q;

    assign slip_en = (state_q == S_BITALIGN) && lane_valid_i;
    assign timeout = (tmr_q == TmW'(TimeoutCycles - 1));

    for (genvar l = 0; l < NumLanes; l++) begin : g_lane
        serial_link_lane_align_lane #(
            .WordWidth   (WordWidth),
            .TrainPattern(TrainPattern),
            .LockCount   (LockCount),
            .MaxSkew     (MaxSkew)
        ) u_lane (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .clr_i    (train_start_i),
            .slip_en_i(slip_en),
            .adv_i    (lane_valid_i),
            .word_i   (lane_data_i[l*WordWidth +: WordWidth]),
            .dly_i    (dly_q[l]),
            .rot_o    (rot[l]),
            .tap_o    (tap[l]),
            .offset_o (offset[l]),
            .locked_o (locked[l])
        );
    end

    // Per-lane delay needed to line every lane up with the latest marker.
    always_comb begin
        arr_max  = '0;
        skew     = '0;
        skew_bad = 1'b0;
        for (int l = 0; l < NumLanes; l++)
            if (arr_q[l] > arr_max) arr_max = arr_q[l];
        for (int l = 0; l < NumLanes; l++) begin
            skew[l] = arr_max - arr_q[l];
            if (skew[l] > WcW'(MaxSkew)) skew_bad = 1'b1;
        end
    end

    // Training FSM with registered status and data outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            wcnt_q  <= '0;
            seen_q  <= '0;
            arr_q   <= '0;
            dly_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (train_start_i) begin
            state_q <= S_BITALIGN;
            tmr_q   <= '0;
            wcnt_q  <= '0;
            seen_q  <= '0;
            arr_q   <= '0;
            dly_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_BITALIGN: begin
                    tmr_q <= tmr_q + TmW'(1);
                    if (&locked) begin
                        state_q <= S_DESKEW;
                        tmr_q   <= '0;
                        wcnt_q  <= '0;
                        seen_q  <= '0;
                        arr_q   <= '0;
                    end else if (timeout) begin
                        state_q <= S_ERROR;
                        err_q   <= 1'b1;
                    end
                end
                S_DESKEW: begin
                    tmr_q <= tmr_q + TmW'(1);
                    if (lane_valid_i) begin
                        wcnt_q <= wcnt_q + WcW'(1);
                        for (int l = 0; l < NumLanes; l++)
                            if (!seen_q[l] && rot[l] == MarkerWord) begin
                                seen_q[l] <= 1'b1;
                                arr_q[l]  <= wcnt_q;
                            end
                    end
                    if (&seen_q) begin
                        if (skew_bad) begin
                            state_q <= S_ERROR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            for (int l = 0; l < NumLanes; l++) dly_q[l] <= DlyW'(skew[l]);
                        end
                    end else if (timeout) begin
                        state_q <= S_ERROR;
                        err_q   <= 1'b1;
                    end
                end
                S_DONE: begin
                    valid_q <= lane_valid_i;
                    data_q  <= tap;
                end
                default: ;
            endcase
        end
    end

    assign data_o        = data_q;
    assign valid_o       = valid_q;
    assign lane_locked_o = locked;
    assign bitslip_o     = offset;
    assign train_done_o  = done_q;
    assign train_err_o   = err_q;
endmodule

// File: tb/tb_serial_link_lane_align.sv
// Randomised bench for serial_link_lane_align. Each lane carries the same
// logical stream (training words, one marker, then random data), physically
// skewed by whole words and rotated right by a fixed number of bits.
module tb_serial_link_lane_align;
    localparam int NL   = 4;
    localparam int W    = 8;
    localparam int OW   = 3;
    localparam int M    = 24;   // logical index of the marker word
    localparam int DMAX = 512;
    localparam logic [W-1:0] TP = 8'hA5;
    localparam logic [W-1:0] MK = 8'h3C;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            lvalid = 1'b0;
    logic [NL*W-1:0] ldata = '0;
    logic [NL*W-1:0] data_o;
    logic            valid_o, done_o, err_o;
    logic [NL-1:0]   locked_o;
    logic [NL*OW-1:0] slip_o;

    int n_cmp = 0;
    int n_bad = 0;
    int rr[NL];
    int ss[NL];
    logic [W-1:0] dat[NL][DMAX];

    serial_link_lane_align dut (
        .clk_i(clk), .rst_ni(rst_n), .train_start_i(start),
        .lane_data_i(ldata), .lane_valid_i(lvalid),
        .data_o(data_o), .valid_o(valid_o), .lane_locked_o(locked_o),
        .bitslip_o(slip_o), .train_done_o(done_o), .train_err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int n);
        logic [W-1:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = {y[0], y[W-1:1]};
        return y;
    endfunction

    // Logical word j of lane l.
    function automatic logic [W-1:0] lword(input int l, input int j);
        if (j < M) return TP;
        if (j == M) return MK;
        return dat[l][j-M-1];
    endfunction

    // One full training run with the skews/rotations in ss/rr.
    task automatic run(input bit exp_err, input int ncyc);
        int g, pg, smax, mk_cyc, dn_cyc, exp_slip;
        bit pv, pdone, v;
        smax = 0;
        for (int l = 0; l < NL; l++) if (ss[l] > smax) smax = ss[l];
        for (int l = 0; l < NL; l++)
            for (int i = 0; i < DMAX; i++) dat[l][i] = W'($urandom);
        @(negedge clk); start = 1'b1; lvalid = 1'b0;
        @(negedge clk); start = 1'b0;
        g = 0; pg = 0; pv = 1'b0; pdone = 1'b0; mk_cyc = -100; dn_cyc = -1;
        for (int c = 0; c < ncyc; c++) begin
            for (int l = 0; l < NL; l++) begin
                exp_slip = (g < rr[l]) ? g : rr[l];
                chk("lock", locked_o[l], (g >= rr[l] + 8));
                chk("bitslip", slip_o[l*OW +: OW], exp_slip);
            end
            chk("valid", valid_o, pdone ? pv : 1'b0);
            if (valid_o && pdone)
                for (int l = 0; l < NL; l++) chk("data", data_o[l*W +: W], lword(l, pg - smax));
            if (done_o && dn_cyc < 0) dn_cyc = c;
            pdone = done_o;
            v = ($urandom_range(3) != 0);
            lvalid = v;
            for (int l = 0; l < NL; l++) ldata[l*W +: W] = rotr(lword(l, g - ss[l]), rr[l]);
            if (v && g == M + smax) mk_cyc = c;
            pv = v; pg = g;
            if (v) g++;
            @(negedge clk);
        end
        chk("train_err", err_o, exp_err);
        chk("train_done", done_o, !exp_err);
        if (!exp_err) chk("done_latency_ok", ((dn_cyc - mk_cyc) >= 1) && ((dn_cyc - mk_cyc) <= 3), 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        #12;
        chk("rst_data", data_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_lock", locked_o, 0);
        chk("rst_slip", slip_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        @(negedge clk); rst_n = 1'b1;

        // aligned, zero skew
        rr = '{0, 0, 0, 0}; ss = '{0, 0, 0, 0};
        run(1'b0, 120);
        // restart from DONE
        start = 1'b1; lvalid = 1'b0;
        @(negedge clk); start = 1'b0;
        chk("restart_done", done_o, 0);
        chk("restart_lock", locked_o, 0);
        chk("restart_slip", slip_o, 0);
        chk("restart_valid", valid_o, 0);

        // bit-slip on lane 2
        rr = '{0, 0, 3, 0}; ss = '{0, 0, 0, 0};
        run(1'b0, 120);
        // skew correction
        rr = '{0, 0, 0, 0}; ss = '{0, 1, 3, 2};
        run(1'b0, 120);
        // skew overflow
        rr = '{0, 0, 0, 0}; ss = '{0, 5, 0, 0};
        run(1'b1, 100);
        // random rotations and legal skews
        for (int t = 0; t < 3; t++) begin
            for (int l = 0; l < NL; l++) begin
                rr[l] = $urandom_range(7);
                ss[l] = $urandom_range(4);
            end
            run(1'b0, 140);
        end

        // reset while in DESKEW
        @(negedge clk); start = 1'b1; lvalid = 1'b0;
        @(negedge clk); start = 1'b0;
        lvalid = 1'b1; ldata = {NL{TP}};
        repeat (14) @(negedge clk);
        chk("pre_rst_lock", locked_o, 4'hF);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_lock", locked_o, 0);
        chk("arst_slip", slip_o, 0);
        chk("arst_done", done_o, 0);
        chk("arst_err", err_o, 0);
        chk("arst_valid", valid_o, 0);
        chk("arst_data", data_o, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_lock", locked_o, 0);
        chk("post_rst_done", done_o, 0);

        // timeout: lane 3 never locks
        start = 1'b1; lvalid = 1'b0; ldata = {8'h00, {3{TP}}};
        @(negedge clk); start = 1'b0; lvalid = 1'b1;
        n = 0;
        while (!err_o && n < 1200) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, 1024);
        chk("timeout_err", err_o, 1);
        chk("timeout_lock", locked_o, 4'h7);
        chk("timeout_done", done_o, 0);
        chk("timeout_valid", valid_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
